// File: rtl/game_event_controller.sv
// Collision, score, lives and game-state controller for a single player against
// NUM_HAZARDS hazard channels and NUM_PICKUPS pickup channels, one event per channel per frame.
module game_event_controller #(
  parameter int unsigned NUM_HAZARDS   = 4,
  parameter int unsigned NUM_PICKUPS   = 2,
  parameter int unsigned SCORE_W       = 8,
  parameter int unsigned LIVES_W       = 3,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned WIN_SCORE     = 20,
  parameter int unsigned INVULN_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   start_game,
  input  logic                   drawing_request_player,
  input  logic [NUM_HAZARDS-1:0] drawing_request_hazard,
  input  logic [NUM_PICKUPS-1:0] drawing_request_pickup,
  output logic                   hazard_hit_pulse,
  output logic [NUM_PICKUPS-1:0] pickup_pulse,
  output logic [SCORE_W-1:0]     score,
  output logic [LIVES_W-1:0]     lives,
  output logic [1:0]             game_state,
  output logic                   invulnerable
);

  localparam int unsigned InvW = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam int unsigned SumW = SCORE_W + 4;

  localparam logic [InvW-1:0]    InvLoad   = InvW'(INVULN_FRAMES);
  localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);
  localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES_INIT);
  localparam logic [SumW-1:0]    ScoreMax  = SumW'({SCORE_W{1'b1}});

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StOver = 2'd2,
    StWon  = 2'd3
  } state_e;

  state_e                 state_q;
  logic [SCORE_W-1:0]     score_q;
  logic [LIVES_W-1:0]     lives_q;
  logic [InvW-1:0]        inv_cnt_q, inv_d, inv_dec;
  logic                   haz_flag_q;
  logic [NUM_PICKUPS-1:0] pk_flag_q;

  logic                   haz_qual, hit, accept;
  logic [NUM_PICKUPS-1:0] pk_qual;
  logic [SumW-1:0]        pk_cnt, score_sum;
  logic [SCORE_W-1:0]     score_sat;

  // A collision qualifies on a fresh flag or on the frame-start cycle itself.
  assign haz_qual = drawing_request_player & (|drawing_request_hazard) &
                    (~haz_flag_q | startOfFrame);
  assign pk_qual  = {NUM_PICKUPS{drawing_request_player}} & drawing_request_pickup &
                    (~pk_flag_q | {NUM_PICKUPS{startOfFrame}});
  assign hit      = haz_qual & (inv_cnt_q == '0);

  // Events are taken only in a live PLAY cycle; the exit cycle just commits the transition.
  assign accept = (state_q == StPlay) && !start_game && (lives_q != '0) && (score_q < WinScore);

  always_comb begin
    pk_cnt = '0;
    for (int j = 0; j < NUM_PICKUPS; j++) begin
      pk_cnt = pk_cnt + SumW'(pk_qual[j]);
    end
    score_sum = SumW'(score_q) + pk_cnt;
    score_sat = (score_sum > ScoreMax) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    inv_dec = (startOfFrame && inv_cnt_q != '0) ? inv_cnt_q - InvW'(1) : inv_cnt_q;
    inv_d   = inv_dec;
    if (!resetN || start_game) begin
      inv_d = '0;
    end else if (accept && hit) begin
      inv_d = InvLoad;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q          <= StIdle;
      score_q          <= '0;
      lives_q          <= LivesInit;
      inv_cnt_q        <= '0;
      invulnerable     <= 1'b0;
      haz_flag_q       <= 1'b0;
      pk_flag_q        <= '0;
      hazard_hit_pulse <= 1'b0;
      pickup_pulse     <= '0;
    end else begin
      inv_cnt_q        <= inv_d;
      invulnerable     <= (inv_d != '0);
      hazard_hit_pulse <= 1'b0;
      pickup_pulse     <= '0;
      if (start_game) begin
        state_q    <= StPlay;
        score_q    <= '0;
        lives_q    <= LivesInit;
        haz_flag_q <= 1'b0;
        pk_flag_q  <= '0;
      end else begin
        case (state_q)
          StPlay: begin
            if (lives_q == '0) begin
              state_q    <= StOver;
              haz_flag_q <= 1'b0;
              pk_flag_q  <= '0;
            end else if (score_q >= WinScore) begin
              state_q    <= StWon;
              haz_flag_q <= 1'b0;
              pk_flag_q  <= '0;
            end else begin
              haz_flag_q   <= haz_qual | (haz_flag_q & ~startOfFrame);
              pk_flag_q    <= pk_qual | (pk_flag_q & ~{NUM_PICKUPS{startOfFrame}});
              pickup_pulse <= pk_qual;
              score_q      <= score_sat;
              if (hit) begin
                hazard_hit_pulse <= 1'b1;
                lives_q          <= lives_q - LIVES_W'(1);
              end
            end
          end
          default: begin
            haz_flag_q <= 1'b0;
            pk_flag_q  <= '0;
          end
        endcase
      end
    end
  end

  assign score      = score_q;
  assign lives      = lives_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_game_event_controller.sv
// Randomised scoreboard bench: a rule-level model predicts each cycle's outputs and a
// negedge monitor pops and compares them against the controller.
module tb_game_event_controller;

  localparam int NH   = 4;
  localparam int NP   = 2;
  localparam int SW   = 4;
  localparam int LW   = 3;
  localparam int LI   = 3;
  localparam int WIN  = 15;
  localparam int INV  = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          startOfFrame = 1'b0;
  logic          start_game = 1'b0;
  logic          player = 1'b0;
  logic [NH-1:0] hazard = '0;
  logic [NP-1:0] pickup = '0;
  logic          hazard_hit_pulse;
  logic [NP-1:0] pickup_pulse;
  logic [SW-1:0] score;
  logic [LW-1:0] lives;
  logic [1:0]    game_state;
  logic          invulnerable;

  game_event_controller #(
    .NUM_HAZARDS  (NH),
    .NUM_PICKUPS  (NP),
    .SCORE_W      (SW),
    .LIVES_W      (LW),
    .LIVES_INIT   (LI),
    .WIN_SCORE    (WIN),
    .INVULN_FRAMES(INV)
  ) dut (
    .clk                   (clk),
    .resetN                (resetN),
    .startOfFrame          (startOfFrame),
    .start_game            (start_game),
    .drawing_request_player(player),
    .drawing_request_hazard(hazard),
    .drawing_request_pickup(pickup),
    .hazard_hit_pulse      (hazard_hit_pulse),
    .pickup_pulse          (pickup_pulse),
    .score                 (score),
    .lives                 (lives),
    .game_state            (game_state),
    .invulnerable          (invulnerable)
  );

  always #5 clk = ~clk;

  typedef struct {
    int      cyc;
    bit      hit;
    bit [NP-1:0] pp;
    int      score;
    int      lives;
    int      st;
    bit      inv;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state (game rules in plain integers)
  int          m_state = 0, m_score = 0, m_lives = LI, m_inv = 0;
  bit          m_hflag = 0;
  bit [NP-1:0] m_pflag = '0;
  bit          m_hit = 0;
  bit [NP-1:0] m_pp = '0;

  task automatic model_step(input bit rst, input bit sof, input bit start, input bit pl,
                            input bit [NH-1:0] hz, input bit [NP-1:0] pk);
    bit qh, q;
    int cnt;
    m_hit = 0;
    m_pp  = '0;
    if (!rst || start) begin
      m_state = rst ? 1 : 0;
      m_score = 0;
      m_lives = LI;
      m_inv   = 0;
      m_hflag = 0;
      m_pflag = '0;
      return;
    end
    if (m_state == 1 && m_lives > 0 && m_score < WIN) begin
      qh = pl && (hz != 0) && (!m_hflag || sof);
      m_hflag = qh || (m_hflag && !sof);
      cnt = 0;
      for (int j = 0; j < NP; j++) begin
        q = pl && pk[j] && (!m_pflag[j] || sof);
        m_pp[j] = q;
        cnt += int'(q);
        m_pflag[j] = q || (m_pflag[j] && !sof);
      end
      m_score = (m_score + cnt > SMAX) ? SMAX : m_score + cnt;
      if (qh && m_inv == 0) begin
        m_hit = 1;
        m_lives--;
        m_inv = INV;
        return;
      end
    end else begin
      if (m_state == 1) m_state = (m_lives == 0) ? 2 : 3;
      m_hflag = 0;
      m_pflag = '0;
    end
    if (sof && m_inv > 0) m_inv--;
  endtask

  task automatic step(input bit rst, input bit sof, input bit start, input bit pl,
                      input bit [NH-1:0] hz, input bit [NP-1:0] pk);
    exp_t e;
    resetN = rst;
    startOfFrame = sof;
    start_game = start;
    player = pl;
    hazard = hz;
    pickup = pk;
    model_step(rst, sof, start, pl, hz, pk);
    e.cyc = cyc + 1;
    e.hit = m_hit;
    e.pp = m_pp;
    e.score = m_score;
    e.lives = m_lives;
    e.st = m_state;
    e.inv = (m_inv != 0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req, input int c);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk("hazard_hit_pulse", 32'(hazard_hit_pulse), 32'(e.hit), e.cyc);
      chk("pickup_pulse", 32'(pickup_pulse), 32'(e.pp), e.cyc);
      chk("score", 32'(score), 32'(e.score), e.cyc);
      chk("lives", 32'(lives), 32'(e.lives), e.cyc);
      chk("game_state", 32'(game_state), 32'(e.st), e.cyc);
      chk("invulnerable", 32'(invulnerable), 32'(e.inv), e.cyc);
    end
  end

  initial begin
    int  frame_cnt;
    bit  sof, start, rst, pl;
    bit [NH-1:0] hz;
    bit [NP-1:0] pk;

    // Directed opening: reset, start, long overlap within one frame, frame-edge re-hit
    repeat (3) step(0, 0, 0, 0, '0, '0);
    step(1, 1, 1, 1, 4'b0100, 2'b01);
    repeat (50) step(1, 0, 0, 1, '0, 2'b01);
    step(1, 1, 0, 1, '0, 2'b01);
    repeat (3) step(1, 0, 0, 0, '0, '0);
    step(1, 1, 0, 1, '0, 2'b11);
    step(1, 0, 0, 1, 4'b0100, '0);
    for (int f = 0; f < 5; f++) begin
      step(1, 1, 0, 0, '0, '0);
      repeat (3) step(1, 0, 0, 1, 4'b0110, '0);
    end
    step(1, 1, 0, 1, 4'b1111, 2'b11);
    step(1, 0, 0, 0, '0, '0);
    step(0, 1, 1, 1, 4'b0001, 2'b11);
    step(1, 0, 0, 0, '0, '0);

    // Randomised play with occasional restarts and mid-game resets
    frame_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      sof = (frame_cnt == 0);
      frame_cnt = sof ? int'($urandom_range(10, 3)) : frame_cnt - 1;
      rst = ($urandom_range(499) != 0);
      start = (m_state != 1) ? ($urandom_range(9) == 0) : ($urandom_range(199) == 0);
      pl = ($urandom_range(99) < 60);
      for (int h = 0; h < NH; h++) hz[h] = ($urandom_range(99) < 6);
      for (int p = 0; p < NP; p++) pk[p] = ($urandom_range(99) < 20);
      step(rst, sof, start, pl, hz, pk);
    end

    step(1, 0, 0, 0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0, cyc);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
